// File: rtl/pipe_shifter_pkg.sv
`default_nettype none
// =============================================================================
// Module   : pipe_shifter_pkg
// Purpose  : Shared mode encoding and default width for the pipelined shifter.
// Revision : 1.0 - initial release
// =============================================================================
package pipe_shifter_pkg;

    localparam int C_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shiftMode_e;

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// =============================================================================
// Module   : shift_stage
// Purpose  : One registered shifter stage moving data by DIST when its amount
//            bit is set; macro PIPE_SHIFTER_ROTATE_EN enables rotate wrap.
// Revision : 1.0 - initial release
// =============================================================================
module shift_stage
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int DIST  = 1,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    input  logic [SH_W-1:0]  inAmt,
    input  shiftMode_e       inMode,
    input  logic             inFill,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [SH_W-1:0]  outAmt,
    output shiftMode_e       outMode,
    output logic             outFill
);

    localparam int C_AMT_BIT = $clog2(DIST);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SH_W-1:0]  r_amt;
    shiftMode_e       r_mode;
    logic             r_fill;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;

    // SRA reuses the current MSB: earlier SRA stages never change the sign bit.
    always_comb begin
        w_shifted = {inData[WIDTH-1-DIST:0], {DIST{inFill}}};
        case (inMode)
            SRL: w_shifted = {{DIST{inFill}}, inData[WIDTH-1:DIST]};
            SRA: w_shifted = {{DIST{inData[WIDTH-1]}}, inData[WIDTH-1:DIST]};
`ifdef PIPE_SHIFTER_ROTATE_EN
            ROL: w_shifted = {inData[WIDTH-1-DIST:0], inData[WIDTH-1:WIDTH-DIST]};
`else
            ROL: w_shifted = {inData[WIDTH-1-DIST:0], {DIST{inFill}}};
`endif
            default: ;
        endcase
        w_next = inAmt[C_AMT_BIT] ? w_shifted : inData;
    end

    assign inReady = !r_valid || outReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= SLL;
            r_fill  <= 1'b0;
        end else if (inReady) begin
            r_valid <= inValid;
            if (inValid) begin
                r_data <= w_next;
                r_amt  <= inAmt;
                r_mode <= inMode;
                r_fill <= inFill;
            end
        end
    end

    assign outValid = r_valid;
    assign outData  = r_data;
    assign outAmt   = r_amt;
    assign outMode  = r_mode;
    assign outFill  = r_fill;

endmodule
`default_nettype wire

// File: rtl/pipe_shifter.sv
`default_nettype none
// =============================================================================
// Module   : pipe_shifter
// Purpose  : SH_W-stage elastic barrel shifter (SLL/SRL/SRA/ROL); mode 11 is a
//            rotate only when PIPE_SHIFTER_ROTATE_EN is defined, else SLL.
// Revision : 1.0 - initial release
// =============================================================================
module pipe_shifter
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] in,
    input  logic [SH_W-1:0]  shAmt,
    input  logic             shBit,
    input  logic [1:0]       mode,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out
);

    // Index k is the input of stage k; index SH_W is the pipeline output.
    logic [SH_W:0]             w_valid;
    logic [SH_W:0]             w_ready;
    logic [SH_W:0][WIDTH-1:0]  w_data;
    logic [SH_W:0][SH_W-1:0]   w_amt;
    logic [SH_W:0][1:0]        w_mode;
    logic [SH_W:0]             w_fill;
    logic                      w_unusedTail;

    assign w_valid[0] = inValid;
    assign inReady    = w_ready[0];
    assign w_data[0]  = in;
    assign w_amt[0]   = shAmt;
    assign w_mode[0]  = mode;
    assign w_fill[0]  = shBit;

    assign w_ready[SH_W] = outReady;
    assign outValid      = w_valid[SH_W];
    assign out           = w_data[SH_W];
    assign w_unusedTail  = ^{w_amt[SH_W], w_mode[SH_W], w_fill[SH_W]};

    generate
        for (genvar k = 0; k < SH_W; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << k),
                .SH_W  (SH_W)
            ) u_stage (
                .clk      (clk),
                .rstN     (rstN),
                .inValid  (w_valid[k]),
                .inReady  (w_ready[k]),
                .inData   (w_data[k]),
                .inAmt    (w_amt[k]),
                .inMode   (shiftMode_e'(w_mode[k])),
                .inFill   (w_fill[k]),
                .outValid (w_valid[k+1]),
                .outReady (w_ready[k+1]),
                .outData  (w_data[k+1]),
                .outAmt   (w_amt[k+1]),
                .outMode  (w_mode[k+1]),
                .outFill  (w_fill[k+1])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_shifter.sv
`default_nettype none
// =============================================================================
// Module   : tb_pipe_shifter
// Purpose  : Directed self-checking bench for pipe_shifter (WIDTH=32).
// Revision : 1.0 - initial release
// =============================================================================
module tb_pipe_shifter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [31:0] in;
    logic [4:0]  shAmt;
    logic        shBit;
    logic [1:0]  mode;
    logic        outValid;
    logic        outReady;
    logic [31:0] out;

    int numChecks = 0;
    int numFails  = 0;

    pipe_shifter #(.WIDTH(32), .SH_W(5)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .in       (in),
        .shAmt    (shAmt),
        .shBit    (shBit),
        .mode     (mode),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Single operation on an idle pipeline; checks acceptance, latency and value.
    task automatic runOp(input string tag, input logic [1:0] m, input logic [31:0] d,
                         input logic [4:0] a, input logic f, input logic [31:0] expected);
        int lat;
        outReady = 1'b1;
        inValid  = 1'b1;
        mode     = m;
        in       = d;
        shAmt    = a;
        shBit    = f;
        #1;
        checkValue({tag, "_inReady"}, 32'(inReady), 32'd1);
        nextCycle();
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 20) begin
            nextCycle();
            lat++;
        end
        checkValue({tag, "_latency"}, 32'(lat), 32'd5);
        checkValue({tag, "_out"}, out, expected);
        nextCycle();
    endtask

    logic [31:0] got[$];
    int          gotCycle[$];
    int          sent;
    int          seenAfterReset;

    initial begin
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        in       = '0;
        shAmt    = '0;
        shBit    = 1'b0;
        mode     = 2'b00;
        #2;
        checkValue("rst_outValid", 32'(outValid), 32'd0);
        checkValue("rst_out", out, 32'd0);
        checkValue("rst_inReady", 32'(inReady), 32'd1);
        repeat (3) @(posedge clk);
        #3;
        rstN = 1'b1;
        nextCycle();
        checkValue("post_rst_inReady", 32'(inReady), 32'd1);
        checkValue("post_rst_outValid", 32'(outValid), 32'd0);

        // Directed vectors, hand-computed results
        runOp("sll31",    2'b00, 32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000);
        runOp("sra4",     2'b10, 32'h8000_0000, 5'd4,  1'b0, 32'hF800_0000);
        runOp("sra4_bit", 2'b10, 32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
        runOp("srl4",     2'b01, 32'h0000_00F0, 5'd4,  1'b1, 32'hF000_000F);
        runOp("sll8_one", 2'b00, 32'h1234_5678, 5'd8,  1'b1, 32'h3456_78FF);
        runOp("sra31_pos",2'b10, 32'h7000_0000, 5'd31, 1'b1, 32'h0000_0000);
        runOp("sra31_neg",2'b10, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFF);
        runOp("srl0",     2'b01, 32'hA5A5_A5A5, 5'd0,  1'b1, 32'hA5A5_A5A5);
        runOp("sra0",     2'b10, 32'hA5A5_A5A5, 5'd0,  1'b1, 32'hA5A5_A5A5);
        runOp("rol0",     2'b11, 32'hA5A5_A5A5, 5'd0,  1'b1, 32'hA5A5_A5A5);
`ifdef PIPE_SHIFTER_ROTATE_EN
        runOp("rol1",     2'b11, 32'h8000_0001, 5'd1,  1'b0, 32'h0000_0003);
        runOp("rol4",     2'b11, 32'h1234_5678, 5'd4,  1'b0, 32'h2345_6781);
`else
        runOp("rol1",     2'b11, 32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002);
        runOp("rol4",     2'b11, 32'h1234_5678, 5'd4,  1'b1, 32'h2345_678F);
`endif

        // Backpressure: 7 ops offered with outReady low, results (i+1)<<i
        outReady = 1'b0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            nextCycle();
            inValid = (sent < 7);
            in      = 32'(sent + 1);
            shAmt   = 5'(sent);
            mode    = 2'b00;
            shBit   = 1'b0;
            #1;
            if (inValid && inReady) sent++;
            if (c >= 8) checkValue("stall_out_stable", out, 32'd1);
        end
        checkValue("stall_accepted", 32'(sent), 32'd5);
        checkValue("stall_inReady", 32'(inReady), 32'd0);
        checkValue("stall_outValid", 32'(outValid), 32'd1);

        outReady = 1'b1;
        got.delete();
        gotCycle.delete();
        for (int c = 0; c < 30 && got.size() < 7; c++) begin
            if (c > 0) nextCycle();
            inValid = (sent < 7);
            in      = 32'(sent + 1);
            shAmt   = 5'(sent);
            #1;
            if (inValid && inReady) sent++;
            if (outValid && outReady) begin
                got.push_back(out);
                gotCycle.push_back(c);
            end
        end
        inValid = 1'b0;
        checkValue("drain_count", 32'(got.size()), 32'd7);
        if (got.size() == 7) begin
            checkValue("drain_r0", got[0], 32'd1);
            checkValue("drain_r1", got[1], 32'd4);
            checkValue("drain_r2", got[2], 32'd12);
            checkValue("drain_r3", got[3], 32'd32);
            checkValue("drain_r4", got[4], 32'd80);
            checkValue("drain_r5", got[5], 32'd192);
            checkValue("drain_r6", got[6], 32'd448);
            checkValue("drain_rate", 32'(gotCycle[6] - gotCycle[0]), 32'd6);
        end
        nextCycle();

        // Streaming: 10 back-to-back SRL ops, outReady held high
        got.delete();
        gotCycle.delete();
        sent = 0;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            if (c > 0) nextCycle();
            inValid = (sent < 10);
            in      = 32'h8000_0000;
            shAmt   = 5'(sent);
            mode    = 2'b01;
            shBit   = 1'b0;
            #1;
            if (sent < 10) checkValue("stream_inReady", 32'(inReady), 32'd1);
            if (inValid && inReady) sent++;
            if (outValid) begin
                got.push_back(out);
                gotCycle.push_back(c);
            end
        end
        inValid = 1'b0;
        checkValue("stream_count", 32'(got.size()), 32'd10);
        if (got.size() == 10) begin
            checkValue("stream_first", got[0], 32'h8000_0000);
            checkValue("stream_r3", got[3], 32'h1000_0000);
            checkValue("stream_last", got[9], 32'h0040_0000);
            checkValue("stream_rate", 32'(gotCycle[9] - gotCycle[0]), 32'd9);
        end
        nextCycle();

        // Reset with operations in flight
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1;
            in      = 32'h0000_00FF;
            shAmt   = 5'(i + 1);
            mode    = 2'b00;
            nextCycle();
        end
        inValid = 1'b0;
        for (int c = 0; c < 20 && !outValid; c++) nextCycle();
        checkValue("inflight_outValid", 32'(outValid), 32'd1);
        #3;
        rstN = 1'b0;
        #1;
        checkValue("midrst_outValid", 32'(outValid), 32'd0);
        checkValue("midrst_out", out, 32'd0);
        checkValue("midrst_inReady", 32'(inReady), 32'd1);
        nextCycle();
        #3;
        rstN = 1'b1;
        outReady = 1'b1;
        seenAfterReset = 0;
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            if (outValid) seenAfterReset++;
        end
        checkValue("rst_no_ghost", 32'(seenAfterReset), 32'd0);
        runOp("after_rst", 2'b01, 32'hFF00_0000, 5'd8, 1'b0, 32'h00FF_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
